ntt_scheduler: RTL and testbench

NTT_SCHEDULER -- requirements
Module: ntt_scheduler

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_wb_delay.sv | 43 ++++
 rtl/ntt_scheduler.sv | 131 +++++++++++++
 tb/tb_ntt_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT butterfly scheduler.
package ntt_pkg;

  localparam int N        = 256;
  localparam int LOGN     = 8;
  localparam int Q        = 8380417;
  localparam int RAM_LAT  = 1;
  localparam int BF_LAT   = 2;
  localparam int PIPE_LAT = RAM_LAT + BF_LAT;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ntt_wb_delay.sv
// Free-running valid-tagged delay line carrying butterfly addresses from
// read issue to write-back. Never stalls; cleared by reset.
module ntt_wb_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         vld_out,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out
);

  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] a_pipe;
  logic [DEPTH-1:0][W-1:0] b_pipe;

  // Shift valid and addresses one stage per cycle; reset drops in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= vld_in;
      a_pipe[0]   <= a_in;
      b_pipe[0]   <= b_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
    end
  end

  assign vld_out = vld_pipe[DEPTH-1];
  assign a_out   = a_pipe[DEPTH-1];
  assign b_out   = b_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_scheduler.sv
// Forward-NTT butterfly scheduler: walks the Dilithium loop nest layer by
// layer, one butterfly per cycle, draining the pipeline between layers so
// that every write of a layer lands before the next layer reads.
module ntt_scheduler #(
  parameter int N       = ntt_pkg::N,
  parameter int RAM_LAT = ntt_pkg::RAM_LAT,
  parameter int BF_LAT  = ntt_pkg::BF_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic       busy,
  output logic       done,
  output logic [2:0] layer,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] zeta_idx,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);
  import ntt_pkg::*;

  localparam int PL   = RAM_LAT + BF_LAT;
  localparam int HALF = N / 2;
  localparam int DW   = (PL > 1) ? $clog2(PL) : 1;

  state_t        state, state_nxt;
  logic [2:0]    layer_q;
  logic [7:0]    j_off;   // offset of j inside the current block
  logic [7:0]    base;    // block start s
  logic [7:0]    zeta;
  logic [6:0]    cnt;     // butterflies issued in this layer
  logic [DW-1:0] dcnt;
  logic [7:0]    len;
  logic          issue, last_issue, block_end, drain_end, last_layer;

  assign len        = 8'(HALF) >> layer_q;
  assign issue      = (state == ISSUE) && !pause;
  assign last_issue = issue && (cnt == 7'(HALF - 1));
  assign block_end  = (j_off == len - 8'd1);
  assign drain_end  = (state == DRAIN) && (dcnt == DW'(PL - 1));
  assign last_layer = (layer_q == 3'(LOGN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = last_layer ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loop-nest counters: hold on pause, advance one butterfly per issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q <= '0;
      j_off   <= '0;
      base    <= '0;
      zeta    <= '0;
      cnt     <= '0;
      dcnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          layer_q <= '0;
          j_off   <= '0;
          base    <= '0;
          zeta    <= 8'd1;
          cnt     <= '0;
          dcnt    <= '0;
        end
        ISSUE: if (issue) begin
          cnt <= cnt + 7'd1;
          if (block_end) begin
            j_off <= '0;
            base  <= base + (len << 1);
            zeta  <= zeta + 8'd1;
          end else begin
            j_off <= j_off + 8'd1;
          end
        end
        DRAIN: if (drain_end) begin
          dcnt  <= '0;
          cnt   <= '0;
          j_off <= '0;
          base  <= '0;
          if (!last_layer) layer_q <= layer_q + 3'd1;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
        DONE: layer_q <= '0;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign layer     = layer_q;
  assign rd_en     = issue;
  assign rd_addr_a = issue ? base + j_off : 8'd0;
  assign rd_addr_b = issue ? base + j_off + len : 8'd0;
  assign zeta_idx  = issue ? zeta : 8'd0;

  ntt_wb_delay #(
    .DEPTH(PL),
    .W    (8)
  ) u_wb_delay (
    .clk    (clk),
    .rst    (rst),
    .vld_in (rd_en),
    .a_in   (rd_addr_a),
    .b_in   (rd_addr_b),
    .vld_out(wr_en),
    .a_out  (wr_addr_a),
    .b_out  (wr_addr_b)
  );

endmodule

// File: tb/tb_ntt_scheduler.sv
// Directed bench for ntt_scheduler: reset state, full transforms with and
// without pause, start-while-busy, mid-transform reset and restart.
module tb_ntt_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] layer;
  logic [7:0] rd_addr_a, rd_addr_b, zeta_idx, wr_addr_a, wr_addr_b;

  ntt_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .busy     (busy),
    .done     (done),
    .layer    (layer),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .zeta_idx (zeta_idx),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int a;
    int b;
    int z;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  n_assert, n_fail;
  int  done_cyc, done_cnt, zero_err, busy_err, layer_err, pause_rd, wr_after_rst;
  logic [31:0] post_busy, post_wr, post_rd, post_layer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle at the falling edge, then let outputs settle.
  task automatic run_cycle(input logic st, input logic ps, input logic rs);
    @(negedge clk);
    start = st;
    pause = ps;
    rst   = rs;
    #1;
  endtask

  // Cycle 0 carries start; records all issue/write events by cycle number.
  task automatic run_transform(input int p_lo, input int p_hi, input int st_again, input int rst_at);
    bit  ended;
    ev_t e;
    ended = 0;
    rdq.delete();
    wrq.delete();
    done_cyc = -1; done_cnt = 0; zero_err = 0; busy_err = 0; layer_err = 0;
    pause_rd = 0; wr_after_rst = 0;
    post_busy = 'x; post_wr = 'x; post_rd = 'x; post_layer = 'x;
    for (int c = 0; c < 1200; c++) begin
      run_cycle(c == 0 || c == st_again, c >= p_lo && c <= p_hi, rst_at >= 0 && c == rst_at);
      if (rd_en === 1'b1) begin
        if (int'(layer) != rdq.size() / 128) layer_err++;
        e.c = c; e.a = int'(rd_addr_a); e.b = int'(rd_addr_b); e.z = int'(zeta_idx);
        rdq.push_back(e);
        if (c >= p_lo && c <= p_hi) pause_rd++;
      end else if (rd_addr_a !== 8'd0 || rd_addr_b !== 8'd0 || zeta_idx !== 8'd0) zero_err++;
      if (wr_en === 1'b1) begin
        e.c = c; e.a = int'(wr_addr_a); e.b = int'(wr_addr_b); e.z = 0;
        wrq.push_back(e);
        if (rst_at >= 0 && c > rst_at) wr_after_rst++;
      end else if (wr_addr_a !== 8'd0 || wr_addr_b !== 8'd0) zero_err++;
      if (busy !== (c >= 1 && !ended)) busy_err++;
      if (busy === 1'b0 && layer !== 3'd0) layer_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        post_busy = 32'(busy); post_wr = 32'(wr_en); post_rd = 32'(rd_en); post_layer = 32'(layer);
      end
      if (done === 1'b1 || (rst_at >= 0 && c == rst_at)) ended = 1;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      if (rst_at >= 0 && c == rst_at + 6) break;
    end
  endtask

  // Reference loop nest: for each layer, blocks of 2*len, j in block, zeta per block.
  task automatic check_seq(input string tag);
    int k, idx, errs, ln;
    k = 1; idx = 0; errs = 0;
    for (int l = 0; l < 8; l++) begin
      ln = 128 >> l;
      for (int s = 0; s < 256; s += 2 * ln) begin
        for (int j = s; j < s + ln; j++) begin
          if (idx >= rdq.size()) errs++;
          else if (rdq[idx].a != j || rdq[idx].b != j + ln || rdq[idx].z != k) errs++;
          idx++;
        end
        k++;
      end
    end
    check(tag, errs, 0);
  endtask

  task automatic check_align(input string tag);
    int errs;
    errs = 0;
    if (wrq.size() != rdq.size()) errs++;
    else
      for (int i = 0; i < rdq.size(); i++)
        if (wrq[i].c != rdq[i].c + 3 || wrq[i].a != rdq[i].a || wrq[i].b != rdq[i].b) errs++;
    check(tag, errs, 0);
  endtask

  task automatic check_ev(input string tag, input int idx, input int c, input int a, input int b, input int z);
    if (idx >= rdq.size()) begin
      check({tag, "_present"}, rdq.size(), idx + 1);
    end else begin
      check({tag, "_cyc"}, rdq[idx].c, c);
      check({tag, "_a"}, rdq[idx].a, a);
      check({tag, "_b"}, rdq[idx].b, b);
      check({tag, "_z"}, rdq[idx].z, z);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; pause = 1'b0;

    // Reset state
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_layer", 32'(layer), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addrs", 32'(rd_addr_a | rd_addr_b | zeta_idx | wr_addr_a | wr_addr_b), 0);

    // Full transform, with a start pulse in cycle 300 that must be ignored
    run_transform(-1, -2, 300, -1);
    check_ev("l0_first", 0, 1, 0, 128, 1);
    check_ev("l0_second", 1, 2, 1, 129, 1);
    check_ev("l0_last", 127, 128, 127, 255, 1);
    check_ev("l1_first", 128, 132, 0, 64, 2);
    check_ev("l1_65th", 192, 196, 128, 192, 3);
    check_ev("final", 1023, 1045, 254, 255, 255);
    check("done_cycle", done_cyc, 1049);
    check("done_pulses", done_cnt, 1);
    check("rd_count", rdq.size(), 1024);
    check("wr_count", wrq.size(), 1024);
    check("busy_window", busy_err, 0);
    check("layer_track", layer_err, 0);
    check("zero_when_idle", zero_err, 0);
    check_seq("issue_order");
    check_align("wb_align");
    if (wrq.size() > 127 && rdq.size() > 128)
      check("raw_hazard", 32'(wrq[127].c < rdq[128].c), 1);
    else
      check("raw_hazard_events", 32'(wrq.size() > 127 && rdq.size() > 128), 1);

    // Pause in cycles 50..59
    run_transform(50, 59, -1, -1);
    check("pause_no_rd", pause_rd, 0);
    check_ev("pause_before", 48, 49, 48, 176, 1);
    check_ev("pause_after", 49, 60, 49, 177, 1);
    check("pause_done_cycle", done_cyc, 1059);
    check("pause_rd_count", rdq.size(), 1024);
    check("pause_busy", busy_err, 0);
    check_seq("pause_order");
    check_align("pause_align");

    // Reset during layer 3
    run_transform(-1, -2, -1, 414);
    check("mid_rd_before_rst", rdq.size(), 405);
    check("mid_post_busy", post_busy, 0);
    check("mid_post_wr", post_wr, 0);
    check("mid_post_rd", post_rd, 0);
    check("mid_post_layer", post_layer, 0);
    check("mid_wr_after_rst", wr_after_rst, 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_busy", busy_err, 0);

    // Restart replays from layer 0
    run_transform(-1, -2, -1, -1);
    check_ev("re_first", 0, 1, 0, 128, 1);
    check_ev("re_second", 1, 2, 1, 129, 1);
    check_ev("re_l0_last", 127, 128, 127, 255, 1);
    check("re_done_cycle", done_cyc, 1049);
    check_seq("re_order");
    check_align("re_align");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
